// File: rtl/core_sequencer.sv
// Fetch/decode/execute controller between the register-file/ALU datapath and one shared memory port.
// Latency: ALU/COND 1+F+1 cycles, LOAD/STORE add the memory wait, CONST adds a second fetch (F = fetch wait incl. ack).
// Backpressure: mem_req is held until mem_ack; a request unanswered for TIMEOUT cycles forces the sticky ERROR state.
//
// Ports:
//   clk, reset_n                  clock; synchronous active-low reset
//   mem_req_o/mem_we_o/addr_sel_o memory request, 1=store, address source (0=PC, 1=datapath mem_loca)
//   mem_ack_i/mem_rdata_i         request accepted; read data valid in the ack cycle
//   pc_inc_o, write_o{Y2,Y1}      datapath PC increment and register write strobes
//   alu_op_o, compare_op_o        ALU / compare operation
//   a_o..d_o, y1_o, y2_o          register selects, held from IR
//   ld_o, const_c_o, constant_o   C-operand source select (load data / constant) and constant value
//   condition_o                   conditional write mode
//   halted_o, error_o             HALT / ERROR reached (sticky until reset)
module core_sequencer #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        addr_sel_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        pc_inc_o,
  output logic [1:0]  write_o,
  output logic [2:0]  alu_op_o,
  output logic [3:0]  a_o,
  output logic [3:0]  b_o,
  output logic [3:0]  c_o,
  output logic [3:0]  d_o,
  output logic [3:0]  y1_o,
  output logic [3:0]  y2_o,
  output logic        ld_o,
  output logic        const_c_o,
  output logic [31:0] constant_o,
  output logic        condition_o,
  output logic [2:0]  compare_op_o,
  output logic        halted_o,
  output logic        error_o
);

  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [3:0] CLS_ALU   = 4'h0;
  localparam logic [3:0] CLS_LOAD  = 4'h1;
  localparam logic [3:0] CLS_STORE = 4'h2;
  localparam logic [3:0] CLS_CONST = 4'h3;
  localparam logic [3:0] CLS_COND  = 4'h4;
  localparam logic [3:0] CLS_HALT  = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_EXEC   = 3'd1,
    S_CFETCH = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  // Only the decoded IR fields are kept: [31:5] and the dual bit [1].
  logic [31:5]     ir_q, ir_d;
  logic            dual_q, dual_d;
  logic [31:0]     const_q, const_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic            asel_q, asel_d;
  logic [WW-1:0]   wait_q, wait_d;

  logic [3:0]      cls;
  logic            acked;
  logic            timeout_hit;
  logic [1:0]      wr;
  logic            pci_raw;
  logic            ld;
  logic            cc;
  logic            cond;

  assign cls         = ir_q[31:28];
  // An ack only counts while a request is actually outstanding.
  assign acked       = req_q && mem_ack_i;
  assign timeout_hit = req_q && !mem_ack_i && (wait_q == WW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    dual_d  = dual_q;
    const_d = const_q;
    wr      = 2'b00;
    pci_raw = 1'b0;
    ld      = 1'b0;
    cc      = 1'b0;
    cond    = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (acked) begin
          ir_d    = mem_rdata_i[31:5];
          dual_d  = mem_rdata_i[1];
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls)
          CLS_ALU: begin
            wr      = {dual_q, 1'b1};
            pci_raw = 1'b1;
            state_d = S_FETCH;
          end
          CLS_COND: begin
            cond    = 1'b1;
            wr      = 2'b01;
            pci_raw = 1'b1;
            state_d = S_FETCH;
          end
          CLS_LOAD, CLS_STORE: begin
            pci_raw = 1'b1;
            state_d = S_MEM;
          end
          CLS_CONST: begin
            pci_raw = 1'b1;
            state_d = S_CFETCH;
          end
          CLS_HALT: state_d = S_HALT;
          default:  state_d = S_ERROR;
        endcase
      end
      S_CFETCH: begin
        if (acked) begin
          const_d = mem_rdata_i;
          cc      = 1'b1;
          wr      = 2'b01;
          pci_raw = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        if (acked) begin
          if (cls == CLS_LOAD) begin
            ld = 1'b1;
            wr = 2'b01;
          end
          state_d = S_FETCH;
        end
      end
      S_HALT:  state_d = S_HALT;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase

    if (timeout_hit) begin
      state_d = S_ERROR;
    end
  end

  // Wait counter restarts whenever no request is pending or one is acked.
  assign wait_d = (req_q && !mem_ack_i) ? wait_q + 1'b1 : '0;

  // Request lines are registered so they stay stable until the ack cycle;
  // after an ack the request drops for at least one cycle.
  assign req_d  = ((state_d == S_FETCH) || (state_d == S_CFETCH) || (state_d == S_MEM)) && !acked;
  assign asel_d = req_d && (state_d == S_MEM);
  assign we_d   = asel_d && (cls == CLS_STORE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      dual_q  <= 1'b0;
      const_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      asel_q  <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      dual_q  <= dual_d;
      const_q <= const_d;
      req_q   <= req_d;
      we_q    <= we_d;
      asel_q  <= asel_d;
      wait_q  <= wait_d;
    end
  end

  assign mem_req_o  = req_q;
  assign mem_we_o   = we_q;
  assign addr_sel_o = asel_q;

  // Register 0 is the PC: never increment it in the same cycle it is written.
  assign pc_inc_o   = pci_raw && !(wr[0] && (ir_q[27:24] == 4'd0))
                              && !(wr[1] && (ir_q[11:8] == 4'd0));
  assign write_o     = wr;
  assign ld_o        = ld;
  assign const_c_o   = cc;
  assign condition_o = cond;
  // The new constant is forwarded in its ack cycle so it lines up with const_c.
  assign constant_o  = cc ? mem_rdata_i : const_q;

  assign y1_o = ir_q[27:24];
  assign a_o  = ir_q[23:20];
  assign b_o  = ir_q[19:16];
  assign c_o  = ir_q[15:12];
  assign d_o  = ir_q[11:8];
  assign y2_o = ir_q[11:8];

  assign alu_op_o     = (cls == CLS_ALU)  ? ir_q[7:5] : 3'd0;
  assign compare_op_o = (cls == CLS_COND) ? ir_q[7:5] : 3'd0;

  assign halted_o = (state_q == S_HALT);
  assign error_o  = (state_q == S_ERROR);

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized bench for core_sequencer: builds an expected per-cycle trace from the instruction stream and ack delays.
// Latency: trace is replayed one record per clock, outputs sampled on the falling edge.
// Backpressure: bench plays the memory, choosing an ack delay for every request.
module tb_core_sequencer;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_req, mem_we, addr_sel, mem_ack;
  logic [31:0] mem_rdata;
  logic        pc_inc, ld, const_c, condition, halted, error;
  logic [1:0]  write;
  logic [2:0]  alu_op, compare_op;
  logic [3:0]  a, b, c, d, y1, y2;
  logic [31:0] constant;

  always #5 clk = ~clk;

  core_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .addr_sel_o(addr_sel),
    .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
    .pc_inc_o(pc_inc), .write_o(write), .alu_op_o(alu_op),
    .a_o(a), .b_o(b), .c_o(c), .d_o(d), .y1_o(y1), .y2_o(y2),
    .ld_o(ld), .const_c_o(const_c), .constant_o(constant),
    .condition_o(condition), .compare_op_o(compare_op),
    .halted_o(halted), .error_o(error)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at trace cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // One expected clock cycle: inputs to drive and outputs to expect.
  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        req, we, asel;
    logic [1:0]  wr;
    logic        pci, ld, cc, cond, hlt, err;
    logic [31:0] cst;
    logic [31:0] ir;
  } rec_t;

  rec_t        tr[$];
  logic [31:0] m_ir, m_cst;
  bit          gap, dead;

  function automatic rec_t blank();
    rec_t r;
    r.ack = 1'b0; r.rdata = $urandom;
    r.req = 1'b0; r.we = 1'b0; r.asel = 1'b0; r.wr = 2'b00;
    r.pci = 1'b0; r.ld = 1'b0; r.cc = 1'b0; r.cond = 1'b0;
    r.hlt = 1'b0; r.err = 1'b0;
    r.cst = m_cst; r.ir = m_ir;
    return r;
  endfunction

  task automatic push_sticky(input bit h);
    rec_t r;
    for (int i = 0; i < 5; i++) begin
      r = blank();
      r.hlt = h; r.err = !h;
      tr.push_back(r);
    end
    dead = 1'b1;
  endtask

  // kind: 0=instruction fetch, 1=constant fetch, 2=load, 3=store
  task automatic req_phase(input int dly, input logic [31:0] data, input int kind);
    rec_t r;
    if (gap) tr.push_back(blank());      // request rises one cycle late
    r = blank();
    r.req  = 1'b1;
    r.asel = (kind >= 2);
    r.we   = (kind == 3);
    if (dly >= TO) begin
      for (int i = 0; i < TO; i++) begin
        r.rdata = $urandom;
        tr.push_back(r);
      end
      push_sticky(1'b0);
      return;
    end
    for (int i = 0; i < dly; i++) begin
      r.rdata = $urandom;
      tr.push_back(r);
    end
    r.ack = 1'b1; r.rdata = data;
    if (kind == 1) begin
      r.cc = 1'b1; r.wr = 2'b01; r.cst = data;
      r.pci = (m_ir[27:24] != 4'd0);
    end
    if (kind == 2) begin
      r.ld = 1'b1; r.wr = 2'b01;
    end
    tr.push_back(r);
    if (kind == 0) m_ir = data;
    if (kind == 1) m_cst = data;
    gap = (kind != 0);
  endtask

  task automatic gen_instr(input logic [31:0] w, input int d1, input int d2, input logic [31:0] cw);
    rec_t r;
    logic [3:0] y1z, y2z;
    if (dead) return;
    req_phase(d1, w, 0);
    if (dead) return;
    y1z = m_ir[27:24];
    y2z = m_ir[11:8];
    r = blank();
    gap = 1'b0;
    case (m_ir[31:28])
      4'h0: begin
        r.wr  = {m_ir[1], 1'b1};
        r.pci = (y1z != 0) && !(m_ir[1] && y2z == 0);
        tr.push_back(r);
      end
      4'h4: begin
        r.cond = 1'b1; r.wr = 2'b01; r.pci = (y1z != 0);
        tr.push_back(r);
      end
      4'h1, 4'h2: begin
        r.pci = 1'b1;
        tr.push_back(r);
        req_phase(d2, $urandom, (m_ir[31:28] == 4'h1) ? 2 : 3);
      end
      4'h3: begin
        r.pci = 1'b1;
        tr.push_back(r);
        req_phase(d2, cw, 1);
      end
      4'hF: begin
        tr.push_back(r);
        push_sticky(1'b1);
      end
      default: begin
        tr.push_back(r);
        push_sticky(1'b0);
      end
    endcase
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 4))
      0: w[31:28] = 4'h0;
      1: w[31:28] = 4'h1;
      2: w[31:28] = 4'h2;
      3: w[31:28] = 4'h3;
      default: w[31:28] = 4'h4;
    endcase
    if ($urandom_range(0, 5) == 0) w[27:24] = 4'h0;
    if ($urandom_range(0, 5) == 0) w[11:8]  = 4'h0;
    return w;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    m_ir = '0; m_cst = '0; gap = 1'b1; dead = 1'b0;
    tr.delete();
    cyc = 0;
  endtask

  // Entered and left at posedge+1.
  task automatic run_trace(input int limit);
    rec_t r;
    logic [31:0] ir;
    int n;
    n = (limit < tr.size()) ? limit : tr.size();
    for (int i = 0; i < n; i++) begin
      r = tr[i];
      ir = r.ir;
      cyc = i;
      mem_ack = r.ack; mem_rdata = r.rdata;
      @(negedge clk);
      chk("mem_req",  32'(mem_req),  32'(r.req));
      chk("mem_we",   32'(mem_we),   32'(r.we));
      chk("addr_sel", 32'(addr_sel), 32'(r.asel));
      chk("write",    32'(write),    32'(r.wr));
      chk("pc_inc",   32'(pc_inc),   32'(r.pci));
      chk("strobes",  32'({ld, const_c, condition}), 32'({r.ld, r.cc, r.cond}));
      chk("status",   32'({halted, error}), 32'({r.hlt, r.err}));
      chk("constant", constant, r.cst);
      chk("selects",  32'({y1, a, b, c, d, y2}),
          32'({ir[27:24], ir[23:20], ir[19:16], ir[15:12], ir[11:8], ir[11:8]}));
      chk("ops", 32'({alu_op, compare_op}),
          32'({(ir[31:28] == 4'h0) ? ir[7:5] : 3'd0, (ir[31:28] == 4'h4) ? ir[7:5] : 3'd0}));
      @(posedge clk);
      #1;
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    int k;
    mem_ack = 1'b0; mem_rdata = '0;

    // Directed program: ALU, CONST, delayed LOAD, STORE, COND, HALT.
    do_reset();
    gen_instr(32'h0312_0000, 0, 0, 0);
    gen_instr(32'h3500_0000, 0, 0, 32'hDEAD_BEEF);
    gen_instr(32'h1700_0000, 1, 5, 0);
    gen_instr(32'h2080_0000, 2, 3, 0);
    gen_instr(32'h4123_40A0, 0, 0, 0);
    gen_instr(32'h0000_0002, 0, 0, 0);
    gen_instr(32'hF000_0000, 1, 0, 0);
    run_trace(tr.size());

    // Fetch timeout, then a single-edge reset clears the sticky error.
    do_reset();
    gen_instr(32'h0312_0000, TO, 0, 0);
    run_trace(tr.size());
    reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("err_cleared", 32'({error, mem_req}), 32'd0);
    @(posedge clk);
    #1;

    // Timeout in the memory phase.
    do_reset();
    gen_instr(32'h0540_0000, 0, 0, 0);
    gen_instr(32'h2610_0000, 0, TO, 0);
    run_trace(tr.size());

    // Reset while a LOAD waits for its ack.
    do_reset();
    gen_instr(32'h1900_0000, 0, 10, 0);
    k = 0;
    for (int i = 0; i < tr.size(); i++) begin
      if (tr[i].asel && k == 0) k = i + 3;
    end
    run_trace(k);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_mem", 32'({mem_req, addr_sel, write, pc_inc, ld}), 32'd0);
    @(posedge clk);
    #1;

    // Random programs ending in HALT or an illegal class.
    for (int s = 0; s < 6; s++) begin
      do_reset();
      for (int i = 0; i < 14; i++) begin
        gen_instr(rand_word(), $urandom_range(0, 3), $urandom_range(0, 4), $urandom);
      end
      gen_instr((s % 2 == 0) ? 32'hF000_0000 : 32'h7123_0000, $urandom_range(0, 2), 0, 0);
      run_trace(tr.size());
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
